// File: rtl/ob_cmd_ingress.sv
// Command ingress FIFO ahead of the order book: drops and counts Op_Nop commands.
// It then issues the stored commands in order on ob's registered command port.
package ob_pkg;
    typedef enum logic [1:0] {
        Op_Nop    = 2'd0,
        Op_Buy    = 2'd1,
        Op_Sell   = 2'd2,
        Op_Cancel = 2'd3
    } opcode_t;

    typedef struct packed {
        logic [15:0] price;
        logic [15:0] qty;
    } order_t;

    typedef union packed {
        order_t      order;
        logic [31:0] target;
    } oprand_u;

    typedef struct packed {
        opcode_t     opcode;
        logic [15:0] uid;
        oprand_u     oprand;
    } cmd_t;
endpackage

module ob_cmd_ingress
    import ob_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  cmd_t                       in_cmd,
    output logic                       in_rdy,
    output logic                       cmd_vld_r,
    output cmd_t                       cmd_r,
    input  logic                       cmd_full_r,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           nop_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             cmd_vld_q, cmd_vld_d;
    cmd_t             cmd_q, cmd_d;
    logic [CNT_W-1:0] nop_cnt_q, nop_cnt_d;

    logic push_acc;
    logic is_nop;
    logic store;
    logic pop;

    // Ready is a function of registered occupancy only, so a pop never frees a same-cycle slot.
    assign in_rdy    = rst && (occ_q != OCC_W'(DEPTH));
    assign cmd_vld_r = cmd_vld_q;
    assign cmd_r     = cmd_q;
    assign occupancy = occ_q;
    assign nop_cnt   = nop_cnt_q;

    always_comb begin
        push_acc  = in_vld && in_rdy;
        is_nop    = (in_cmd.opcode == Op_Nop);
        store     = push_acc && !is_nop;
        pop       = !cmd_full_r && (occ_q != '0);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        cmd_vld_d = pop;
        cmd_d     = cmd_q;
        nop_cnt_d = nop_cnt_q;

        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cmd_d    = mem_q[rd_ptr_q];
        end
        case ({store, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        if (push_acc && is_nop && (nop_cnt_q != '1)) begin
            nop_cnt_d = nop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            cmd_vld_q <= 1'b0;
            cmd_q     <= '0;
            nop_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            nop_cnt_q <= nop_cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= in_cmd;
        end
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(push_acc && (occ_q == OCC_W'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
        !(pop && (occ_q == '0)));
    a_full_blocks: assert property (@(posedge clk) disable iff (!rst)
        cmd_full_r |=> !cmd_vld_q);
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst)
        occ_q <= OCC_W'(DEPTH));
`endif
endmodule
